sa_seq_ctrl: RTL

Phase sequencer for the 32x32 systolic array, and the driver side of the array's 6-bit enable counter. It drives that counter's enable and consumes its count, walking the array through three phases: weight load, activation feed, and result drain. It sits in the array top level next to the counter instance and produces the per-phase strobes consumed by the PE grid and the output collector.

---
 rtl/sa_ctrl_pkg.sv | 30 +++
 rtl/sa_seq_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and phase-length helpers for the systolic-array phase sequencer.
// Phase lengths are elaboration-time constants derived from the array dimension.
package sa_ctrl_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_GAP_A  = 3'd2,
        ST_FEED   = 3'd3,
        ST_GAP_B  = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic int len_w(input int n);
        return n;
    endfunction

    function automatic int len_x(input int n);
        return n;
    endfunction

    // Drain covers the full diagonal skew of an n x n array.
    function automatic int len_d(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_seq_ctrl.sv
// Walks the array through weight load, activation feed and result drain, driving the external enable counter.
// Outputs are registered Moore decodes; start/abort act one edge after sampling; no backpressure, start while busy is dropped.
module sa_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    output logic             cnt_en,
    output logic             w_load,
    output logic             x_valid,
    output logic             drain_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(len_w(N) - 1);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(len_x(N) - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(len_d(N) - 1);

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   cnt_en_q, w_load_q, x_valid_q, drain_valid_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_W;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD_W: begin
                if (count > W_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (count == W_LAST) begin
                    state_d = ST_GAP_A;
                end
            end
            ST_GAP_A: state_d = ST_FEED;
            ST_FEED: begin
                if (count > X_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (count == X_LAST) begin
                    state_d = ST_GAP_B;
                end
            end
            ST_GAP_B: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (count > D_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (count == D_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including an overrun and a start in IDLE; err is left alone.
        if (abort) begin
            state_d = ST_IDLE;
            err_d   = err_q;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q without a combinational path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            err_q         <= 1'b0;
            cnt_en_q      <= 1'b0;
            w_load_q      <= 1'b0;
            x_valid_q     <= 1'b0;
            drain_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            cnt_en_q      <= (state_d == ST_LOAD_W) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
            w_load_q      <= (state_d == ST_LOAD_W);
            x_valid_q     <= (state_d == ST_FEED);
            drain_valid_q <= (state_d == ST_DRAIN);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
        end
    end

    assign cnt_en      = cnt_en_q;
    assign w_load      = w_load_q;
    assign x_valid     = x_valid_q;
    assign drain_valid = drain_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
